// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt front-end: default source count,
// register map and STATUS field layout.
package irq_pkg;

    localparam int unsigned IRQ_NUM_DEF = 6;

    typedef enum logic [1:0] {
        IRQ_PEND = 2'd0,
        IRQ_MASK = 2'd1,
        IRQ_MODE = 2'd2,
        IRQ_STAT = 2'd3
    } irq_reg_e;

    localparam int unsigned STAT_ID_LSB    = 0;
    localparam int unsigned STAT_ID_W      = 3;
    localparam int unsigned STAT_VALID_BIT = 4;

endpackage

// File: rtl/irq_sync.sv
// Single-bit synchronizer with an edge-history flop; rise_o flags a
// synchronized 0->1 transition for one cycle.
module irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt front-end for coprocessor 0: synchronizes request lines, latches
// edge/level pending state, masks it and withholds delivery at exception level.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = IRQ_NUM_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_raw,
    input  logic               exl,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [31:0]        wd,
    output logic [31:0]        rd,
    output logic [NUM_IRQ-1:0] interrupt,
    output logic [2:0]         irq_id,
    output logic               irq_valid
);

    logic [NUM_IRQ-1:0] s, rise;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] intr_q, intr_d;
    logic [NUM_IRQ-1:0] w1c, sw_set, edge_pend;
    logic               unused_wd;

    assign unused_wd = ^wd[31:NUM_IRQ];

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst   (rst),
            .irq_i (irq_raw[g]),
            .s_o   (s[g]),
            .rise_o(rise[g])
        );
    end

    always_comb begin
        w1c    = '0;
        sw_set = '0;
        mask_d = mask_q;
        mode_d = mode_q;
        if (we) begin
            unique case (irq_reg_e'(addr))
                IRQ_PEND: w1c    = wd[NUM_IRQ-1:0];
                IRQ_MASK: mask_d = wd[NUM_IRQ-1:0];
                IRQ_MODE: mode_d = wd[NUM_IRQ-1:0];
                IRQ_STAT: sw_set = wd[NUM_IRQ-1:0];
            endcase
        end
        // Set terms are ORed after the clear so a same-cycle set beats W1C.
        edge_pend = (pend_q & ~w1c) | rise | sw_set;
        pend_d    = (mode_q & edge_pend) | (~mode_q & s);
        intr_d    = exl ? '0 : (pend_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
            intr_q <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            intr_q <= intr_d;
        end
    end

    assign interrupt = intr_q;
    assign irq_valid = |intr_q;

    // Descending scan: the lowest-numbered asserted bit is assigned last.
    always_comb begin
        irq_id = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (intr_q[i-1]) irq_id = 3'(i - 1);
        end
    end

    always_comb begin
        rd = '0;
        unique case (irq_reg_e'(addr))
            IRQ_PEND: rd[NUM_IRQ-1:0] = pend_q;
            IRQ_MASK: rd[NUM_IRQ-1:0] = mask_q;
            IRQ_MODE: rd[NUM_IRQ-1:0] = mode_q;
            IRQ_STAT: begin
                rd[STAT_VALID_BIT]              = irq_valid;
                rd[STAT_ID_LSB +: STAT_ID_W]    = irq_id;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expectations are queued alongside stimulus
// and drained against the DUT outputs one cycle-accurate step at a time.
`timescale 1ns/1ps
module tb_irq_ctrl;

    localparam int SEL_INTR  = 4;
    localparam int SEL_ID    = 5;
    localparam int SEL_VALID = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  irq_raw;
    logic        exl;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [5:0]  interrupt;
    logic [2:0]  irq_id;
    logic        irq_valid;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    irq_ctrl #(
        .NUM_IRQ    (6),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_raw  (irq_raw),
        .exl      (exl),
        .we       (we),
        .addr     (addr),
        .wd       (wd),
        .rd       (rd),
        .interrupt(interrupt),
        .irq_id   (irq_id),
        .irq_valid(irq_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        wd   = '0;
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                SEL_INTR:  obs = {26'b0, interrupt};
                SEL_ID:    obs = {29'b0, irq_id};
                SEL_VALID: obs = {31'b0, irq_valid};
                default: begin
                    addr = e.sel[1:0];
                    #0.5;
                    obs = rd;
                end
            endcase
            check_eq(e.tag, obs, e.val);
        end
    endtask

    task automatic push_all_zero(input string pfx);
        push({pfx, "_intr"},  SEL_INTR,  32'h0);
        push({pfx, "_valid"}, SEL_VALID, 32'h0);
        push({pfx, "_id"},    SEL_ID,    32'h0);
        for (int a = 0; a < 4; a++) push($sformatf("%s_rd%0d", pfx, a), a, 32'h0);
    endtask

    initial begin
        rst = 1'b1; irq_raw = '0; exl = 1'b0; we = 1'b0; addr = '0; wd = '0;
        tick(2);
        push_all_zero("reset");
        drain();
        rst = 1'b0;

        // 1: level mode latency and release
        wr(2'd1, 32'h3F);
        wr(2'd2, 32'h00);
        push("mask_rb", 1, 32'h3F);
        drain();
        irq_raw = 6'b000100;
        tick(3);
        push("lvl_e3_intr", SEL_INTR, 32'h0);
        push("lvl_e3_pend", 0, 32'h04);
        drain();
        tick();
        push("lvl_e4_intr",  SEL_INTR,  32'h04);
        push("lvl_e4_id",    SEL_ID,    32'h2);
        push("lvl_e4_valid", SEL_VALID, 32'h1);
        push("lvl_e4_stat",  3,         32'h12);
        drain();
        irq_raw = '0;
        tick(3);
        push("lvl_rel_pend", 0, 32'h0);
        drain();
        tick();
        push("lvl_rel_intr", SEL_INTR, 32'h0);
        drain();

        // 2: edge latch survives release; W1C clears
        wr(2'd2, 32'h3F);
        irq_raw[5] = 1'b1;
        tick(2);
        irq_raw[5] = 1'b0;
        tick(5);
        push("edge_latch_pend", 0,        32'h20);
        push("edge_latch_intr", SEL_INTR, 32'h20);
        push("edge_latch_id",   SEL_ID,   32'h5);
        drain();
        wr(2'd0, 32'h20);
        push("w1c_pend", 0, 32'h0);
        drain();
        tick();
        push("w1c_intr", SEL_INTR, 32'h0);
        drain();

        // 3: simultaneous sources and priority
        irq_raw = 6'b010010;
        tick(5);
        push("dual_intr", SEL_INTR, 32'h12);
        push("dual_id",   SEL_ID,   32'h1);
        push("dual_stat", 3,        32'h11);
        drain();
        wr(2'd0, 32'h02);
        tick();
        push("dual_clr_intr", SEL_INTR, 32'h10);
        push("dual_clr_id",   SEL_ID,   32'h4);
        drain();

        // 4: exception level withholds delivery
        exl = 1'b1;
        tick();
        push("exl_intr",  SEL_INTR,  32'h0);
        push("exl_valid", SEL_VALID, 32'h0);
        push("exl_pend",  0,         32'h10);
        drain();
        tick(2);
        push("exl_hold_intr", SEL_INTR, 32'h0);
        drain();
        exl = 1'b0;
        tick();
        push("exl_exit_intr", SEL_INTR, 32'h10);
        drain();
        irq_raw = '0;
        tick(3);
        wr(2'd0, 32'h3F);
        push("cleanup_pend", 0, 32'h0);
        drain();

        // 5: hardware set beats W1C, then software set
        irq_raw[0] = 1'b1;
        tick(2);
        wr(2'd0, 32'h01);
        push("set_wins_pend", 0, 32'h01);
        drain();
        wr(2'd3, 32'h08);
        push("swset_pend", 0, 32'h09);
        drain();

        // 6: reset discards everything
        wr(2'd3, 32'h3F);
        tick();
        push("pre_rst_intr", SEL_INTR, 32'h3F);
        push("pre_rst_pend", 0,        32'h3F);
        drain();
        rst = 1'b1;
        tick();
        push_all_zero("midrst");
        drain();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
